systolic_array: RTL and testbench

//  Weight-stationary N_SIZE x N_SIZE MAC array for the BERT matmul datapath.

---
 rtl/systolic_array_if.sv | 42 ++++
 rtl/systolic_array.sv | 129 ++++++++++++
 tb/tb_systolic_array.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/systolic_array_if.sv
// -----------------------------------------------------------------------------
// systolic_array_if
// Purpose : bundles the operand/weight/result signals of the weight-stationary
//           systolic MAC array so a controller and the array share one port.
// Signals :
//   wt_en     load every PE weight from wt_flat on this edge
//   valid_in  advance the MAC pipeline on this edge
//   matrix_A  [N_SIZE] x DATAWIDTH, A[i] feeds array row i (caller-skewed)
//   matrix_B  [N_SIZE] x 4*DATAWIDTH, partial-sum seed per column (row 0)
//   wt_flat   [N_SIZE*N_SIZE] x DATAWIDTH, wt_flat[i*N_SIZE+j] -> PE(i,j)
//   matrix_C  [N_SIZE] x 4*DATAWIDTH, registered psum leaving the bottom row
// Modports: master = controller side, slave = array side.
// -----------------------------------------------------------------------------
interface systolic_array_if #(
    parameter int DATAWIDTH = 8,
    parameter int N_SIZE    = 2
);
    logic                                         wt_en;
    logic                                         valid_in;
    logic [N_SIZE-1:0][DATAWIDTH-1:0]             matrix_A;
    logic [N_SIZE-1:0][4*DATAWIDTH-1:0]           matrix_B;
    logic [N_SIZE*N_SIZE-1:0][DATAWIDTH-1:0]      wt_flat;
    logic [N_SIZE-1:0][4*DATAWIDTH-1:0]           matrix_C;

    modport master (
        output wt_en,
        output valid_in,
        output matrix_A,
        output matrix_B,
        output wt_flat,
        input  matrix_C
    );

    modport slave (
        input  wt_en,
        input  valid_in,
        input  matrix_A,
        input  matrix_B,
        input  wt_flat,
        output matrix_C
    );
endinterface

// File: rtl/systolic_array.sv
// -----------------------------------------------------------------------------
// systolic_array
// Purpose : weight-stationary N_SIZE x N_SIZE signed MAC array. Each input row
//           produces one N-wide output row of C = B + A*W. A[i] is broadcast
//           across array row i, partial sums flow down each column and leave
//           the bottom row as matrix_C (a PE register, no extra logic).
// Ports   :
//   clk    rising-edge clock
//   rst_n  synchronous reset, active HIGH (1 = reset); clears weights and
//          psums and overrides wt_en / valid_in
//   bus    systolic_array_if.slave (wt_en, valid_in, matrix_A, matrix_B,
//          wt_flat in; matrix_C out)
// -----------------------------------------------------------------------------

// -----------------------------------------------------------------------------
// systolic_pe
// Purpose : one processing element: weight register, signed multiply, and
//           psum register accumulating modulo 2^(4*DATAWIDTH).
// Ports   :
//   clk, rst_n  as above (rst_n active high, synchronous)
//   wt_en       load wt_in into the weight register
//   valid_in    update psum with psum_in + a_in*weight
//   a_in        signed activation for this PE's row
//   wt_in       new weight value
//   psum_in     partial sum from the PE above (or matrix_B for row 0)
//   psum_out    registered partial sum to the PE below
// -----------------------------------------------------------------------------
module systolic_pe #(
    parameter int DATAWIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wt_en,
    input  logic                     valid_in,
    input  logic [DATAWIDTH-1:0]     a_in,
    input  logic [DATAWIDTH-1:0]     wt_in,
    input  logic [4*DATAWIDTH-1:0]   psum_in,
    output logic [4*DATAWIDTH-1:0]   psum_out
);
    logic [DATAWIDTH-1:0]            w_q;
    logic [DATAWIDTH-1:0]            w_d;
    logic [4*DATAWIDTH-1:0]          psum_q;
    logic [4*DATAWIDTH-1:0]          psum_d;
    logic signed [2*DATAWIDTH-1:0]   prod_s;
    logic [4*DATAWIDTH-1:0]          prod_ext_s;

    // Signed product with the currently held weight; when a new weight is
    // loaded on the same edge, this still uses the old one.
    always_comb begin
        prod_s     = $signed(a_in) * $signed(w_q);
        prod_ext_s = {{(2*DATAWIDTH){prod_s[2*DATAWIDTH-1]}}, prod_s};
    end

    // Next-state for the weight register.
    always_comb begin
        w_d = w_q;
        if (wt_en) begin
            w_d = wt_in;
        end else begin
            w_d = w_q;
        end
    end

    // Next-state for the psum register; holds while the pipeline is stalled.
    always_comb begin
        psum_d = psum_q;
        if (valid_in) begin
            psum_d = psum_in + prod_ext_s;
        end else begin
            psum_d = psum_q;
        end
    end

    // Weight and psum registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            w_q    <= {DATAWIDTH{1'b0}};
            psum_q <= {(4*DATAWIDTH){1'b0}};
        end else begin
            w_q    <= w_d;
            psum_q <= psum_d;
        end
    end

    assign psum_out = psum_q;
endmodule

module systolic_array #(
    parameter int DATAWIDTH = 8,
    parameter int N_SIZE    = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    systolic_array_if.slave   bus
);
    // psum_s[i][j] is the registered psum of PE(i,j).
    logic [4*DATAWIDTH-1:0] psum_s [N_SIZE][N_SIZE];

    for (genvar i = 0; i < N_SIZE; i++) begin : g_row
        for (genvar j = 0; j < N_SIZE; j++) begin : g_col
            logic [4*DATAWIDTH-1:0] psum_in_s;

            // Row 0 is seeded from matrix_B, deeper rows from the PE above.
            if (i == 0) begin : g_seed
                assign psum_in_s = bus.matrix_B[j];
            end else begin : g_chain
                assign psum_in_s = psum_s[i-1][j];
            end

            systolic_pe #(
                .DATAWIDTH (DATAWIDTH)
            ) u_pe (
                .clk      (clk),
                .rst_n    (rst_n),
                .wt_en    (bus.wt_en),
                .valid_in (bus.valid_in),
                .a_in     (bus.matrix_A[i]),
                .wt_in    (bus.wt_flat[i*N_SIZE+j]),
                .psum_in  (psum_in_s),
                .psum_out (psum_s[i][j])
            );
        end
    end

    // Output is the bottom-row PE register directly, all columns aligned.
    for (genvar j = 0; j < N_SIZE; j++) begin : g_out
        assign bus.matrix_C[j] = psum_s[N_SIZE-1][j];
    end
endmodule

// File: tb/tb_systolic_array.sv
module tb_systolic_array;
    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    int   a_m [4][4];
    int   w_m [4][4];
    // Hand-computed expected output rows: [tile][row][col]
    //  0: A[:,0:2]*W[0:2,0:2]        1: tile 0 + A[:,2:4]*W[2:4,0:2]
    //  2: A[:,0:2]*W[0:2,2:4]        3: tile 2 + A[:,2:4]*W[2:4,2:4]
    int   exp_t [4][4][2] = '{
        '{'{11, 14},  '{35, 46},  '{59, 78},  '{83, 110}},
        '{'{90, 100}, '{202, 228}, '{314, 356}, '{426, 484}},
        '{'{17, 20},  '{57, 68},  '{97, 116}, '{137, 164}},
        '{'{110, 120}, '{254, 280}, '{398, 440}, '{542, 600}}
    };

    systolic_array_if #(.DATAWIDTH(8), .N_SIZE(2)) bus ();

    systolic_array #(.DATAWIDTH(8), .N_SIZE(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.wt_en    = 1'b0;
        bus.valid_in = 1'b0;
        bus.matrix_A = '0;
        bus.matrix_B = '0;
        bus.wt_flat  = '0;
    endtask

    // Load 2x2 weight tile W[kb:kb+2][jb:jb+2] in one idle cycle.
    task automatic load_w(input int kb, input int jb);
        bus.wt_en    = 1'b1;
        bus.valid_in = 1'b0;
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++)
                bus.wt_flat[i*2+j] = 8'(w_m[kb+i][jb+j]);
        cyc();
        bus.wt_en = 1'b0;
    endtask

    // Stream 4 rows of A[:,kb:kb+2] with skew; B from tile bsel (-1 = zero);
    // check C against tile esel after edges 1..4; optional 2-cycle stall.
    task automatic run_tile(input int kb, input int bsel, input int esel,
                            input int hold_at, input string tag);
        for (int c = 0; c < 5; c++) begin
            if (c == hold_at) begin
                for (int h = 0; h < 2; h++) begin
                    bus.valid_in    = 1'b0;
                    bus.matrix_A[0] = 8'($urandom_range(255, 1));
                    bus.matrix_A[1] = 8'($urandom_range(255, 1));
                    bus.matrix_B[0] = 32'($urandom);
                    bus.matrix_B[1] = 32'($urandom);
                    cyc();
                    for (int j = 0; j < 2; j++)
                        chk($sformatf("%s_hold%0d_c%0d", tag, h, j), bus.matrix_C[j],
                            32'(exp_t[esel][c-2][j]));
                end
            end
            bus.valid_in    = 1'b1;
            bus.matrix_A[0] = (c < 4) ? 8'(a_m[c][kb]) : 8'd0;
            bus.matrix_A[1] = (c >= 1) ? 8'(a_m[c-1][kb+1]) : 8'd0;
            for (int j = 0; j < 2; j++)
                bus.matrix_B[j] = (bsel >= 0 && c < 4) ? 32'(exp_t[bsel][c][j]) : 32'd0;
            cyc();
            if (c >= 1)
                for (int j = 0; j < 2; j++)
                    chk($sformatf("%s_row%0d_c%0d", tag, c-1, j), bus.matrix_C[j],
                        32'(exp_t[esel][c-1][j]));
        end
        idle_inputs();
    endtask

    initial begin
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                a_m[r][c] = r*4 + c + 1;
                w_m[r][c] = r*4 + c + 1;
            end
        idle_inputs();

        // 1. Reset, then idle with valid low
        rst_n = 1'b1;
        cyc();
        cyc();
        chk("rst_c0", bus.matrix_C[0], 32'd0);
        chk("rst_c1", bus.matrix_C[1], 32'd0);
        rst_n = 1'b0;
        cyc();
        cyc();
        chk("idle_c0", bus.matrix_C[0], 32'd0);
        chk("idle_c1", bus.matrix_C[1], 32'd0);

        // 2..4. Tiled matmul with feedback accumulation
        load_w(0, 0);
        run_tile(0, -1, 0, -1, "t2");
        load_w(2, 0);
        run_tile(2, 0, 1, -1, "t3");
        load_w(0, 2);
        run_tile(0, -1, 2, -1, "t4a");
        load_w(2, 2);
        run_tile(2, 2, 3, -1, "t4b");

        // 5a. Stall mid-stream: C frozen, results unchanged after resume
        load_w(0, 0);
        run_tile(0, -1, 0, 3, "t5hold");

        // 5b. wt_en with valid_in: MAC uses old weights {1,2,5,6}
        bus.wt_en    = 1'b1;
        bus.valid_in = 1'b1;
        bus.wt_flat[0] = 8'd9;
        bus.wt_flat[1] = 8'd10;
        bus.wt_flat[2] = 8'd13;
        bus.wt_flat[3] = 8'd14;
        bus.matrix_A[0] = 8'd1;
        bus.matrix_A[1] = 8'd0;
        cyc();
        bus.wt_en       = 1'b0;
        bus.matrix_A[0] = 8'd0;
        bus.matrix_A[1] = 8'd2;
        cyc();
        // P0 = [1*1, 1*2]; then + 2*new W row1 = [1+26, 2+28]
        chk("t5ovl_c0", bus.matrix_C[0], 32'd27);
        chk("t5ovl_c1", bus.matrix_C[1], 32'd30);
        idle_inputs();

        // 6a. Signed: A=-1, W0={2,-128}, W1=0 -> C=[-2, 128]
        bus.wt_en      = 1'b1;
        bus.wt_flat[0] = 8'd2;
        bus.wt_flat[1] = 8'h80;
        bus.wt_flat[2] = 8'd0;
        bus.wt_flat[3] = 8'd0;
        cyc();
        idle_inputs();
        bus.valid_in    = 1'b1;
        bus.matrix_A[0] = 8'hFF;
        cyc();
        bus.matrix_A[0] = 8'd0;
        cyc();
        chk("t6neg_c0", bus.matrix_C[0], 32'hFFFF_FFFE);
        chk("t6neg_c1", bus.matrix_C[1], 32'd128);
        idle_inputs();

        // 6b. Wrap: B=0xFFFFFFFF plus A*W=1 -> 0
        bus.wt_en      = 1'b1;
        bus.wt_flat[0] = 8'd1;
        bus.wt_flat[1] = 8'd1;
        cyc();
        idle_inputs();
        bus.valid_in    = 1'b1;
        bus.matrix_A[0] = 8'd1;
        bus.matrix_B[0] = 32'hFFFF_FFFF;
        bus.matrix_B[1] = 32'hFFFF_FFFF;
        cyc();
        bus.matrix_A[0] = 8'd0;
        bus.matrix_B    = '0;
        cyc();
        chk("t6wrap_c0", bus.matrix_C[0], 32'd0);
        chk("t6wrap_c1", bus.matrix_C[1], 32'd0);

        // Mid-operation reset overrides wt_en/valid_in; weights left at 0
        bus.valid_in    = 1'b1;
        bus.matrix_A[0] = 8'd3;
        bus.matrix_A[1] = 8'd3;
        cyc();
        rst_n           = 1'b1;
        bus.wt_en       = 1'b1;
        bus.wt_flat[0]  = 8'd7;
        bus.wt_flat[1]  = 8'd7;
        bus.wt_flat[2]  = 8'd7;
        bus.wt_flat[3]  = 8'd7;
        cyc();
        chk("midrst_c0", bus.matrix_C[0], 32'd0);
        chk("midrst_c1", bus.matrix_C[1], 32'd0);
        rst_n      = 1'b0;
        bus.wt_en  = 1'b0;
        cyc();
        cyc();
        chk("postrst_c0", bus.matrix_C[0], 32'd0);
        chk("postrst_c1", bus.matrix_C[1], 32'd0);
        idle_inputs();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
